// File: rtl/maxnet_iter_scheduler.sv
// Iteration scheduler for the max-set datapath: sequences load/multiply/sum
// strobes and repeats suppression until exactly one process unit stays active.
module maxnet_iter_scheduler #(
    parameter int N        = 4,
    parameter int MAX_ITER = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [N-1:0]         active,
    output logic                 read,
    output logic                 load_y,
    output logic                 select_y,
    output logic                 load_mult,
    output logic                 load_sum,
    output logic                 busy,
    output logic                 done,
    output logic [$clog2(N)-1:0] winner_idx,
    output logic [7:0]           iter_count,
    output logic [1:0]           err
);

    // state  | meaning
    // IDLE   | waiting for start, all strobes low
    // LOAD   | load X/W and Y (Y from X)
    // MULT   | capture products
    // SUM    | capture sums / activation
    // CHECK  | count active units, decide winner / error / next iteration
    // UPDATE | reload Y from process-unit outputs
    // FIN    | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_MULT, S_SUM, S_CHECK, S_UPDATE, S_FIN
    } state_t;

    localparam int IW = $clog2(N);

    state_t     state;
    logic [7:0] act_cnt;
    logic [7:0] iter_inc;
    logic [IW-1:0] act_idx;

    always_comb begin
        act_cnt = '0;
        act_idx = '0;
        for (int i = 0; i < N; i++) begin
            act_cnt = act_cnt + 8'(active[i]);
            if (active[i]) act_idx = IW'(i);
        end
    end

    assign iter_inc = (iter_count == 8'hFF) ? 8'hFF : iter_count + 8'd1;

    // Strobes are registered for the state being entered, so they depend
    // only on the state register and never combinationally on active.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            read       <= 1'b0;
            load_y     <= 1'b0;
            select_y   <= 1'b0;
            load_mult  <= 1'b0;
            load_sum   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            winner_idx <= '0;
            iter_count <= '0;
            err        <= 2'b00;
        end else begin
            read      <= 1'b0;
            load_y    <= 1'b0;
            select_y  <= 1'b0;
            load_mult <= 1'b0;
            load_sum  <= 1'b0;
            done      <= 1'b0;
            if (abort && state != S_IDLE && state != S_FIN) begin
                state <= S_FIN;
                done  <= 1'b1;
                err   <= 2'b11;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            state      <= S_LOAD;
                            read       <= 1'b1;
                            load_y     <= 1'b1;
                            busy       <= 1'b1;
                            iter_count <= '0;
                            err        <= 2'b00;
                        end
                    end
                    S_LOAD, S_UPDATE: begin
                        state     <= S_MULT;
                        load_mult <= 1'b1;
                    end
                    S_MULT: begin
                        state    <= S_SUM;
                        load_sum <= 1'b1;
                    end
                    S_SUM: state <= S_CHECK;
                    S_CHECK: begin
                        iter_count <= iter_inc;
                        if (act_cnt == 8'd1) begin
                            state      <= S_FIN;
                            done       <= 1'b1;
                            winner_idx <= act_idx;
                            err        <= 2'b00;
                        end else if (act_cnt == 8'd0) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                            err   <= 2'b01;
                        end else if (iter_inc == 8'(MAX_ITER)) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                            err   <= 2'b10;
                        end else begin
                            state    <= S_UPDATE;
                            load_y   <= 1'b1;
                            select_y <= 1'b1;
                        end
                    end
                    S_FIN: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_maxnet_iter_scheduler.sv
// Directed bench for maxnet_iter_scheduler: per-scenario tasks with
// hand-computed cycle numbers, counting checks and errors.
module tb_maxnet_iter_scheduler;

    logic       clock, reset, start, abort;
    logic [3:0] active;
    logic       read, load_y, select_y, load_mult, load_sum, busy, done;
    logic [1:0] winner_idx;
    logic [7:0] iter_count;
    logic [1:0] err;

    int errors = 0;
    int checks = 0;

    logic [3:0] act_tab [0:3];
    int act_len;
    int n_read, n_mult, n_sum, n_upd, done_cyc;
    logic busy_after;

    maxnet_iter_scheduler #(.N(4), .MAX_ITER(16)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .active(active), .read(read), .load_y(load_y), .select_y(select_y),
        .load_mult(load_mult), .load_sum(load_sum), .busy(busy), .done(done),
        .winner_idx(winner_idx), .iter_count(iter_count), .err(err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Start a run at edge 0 and follow it until done; active is presented
    // during each CHECK cycle (4, 8, 12, ...) from act_tab.
    task automatic run_seq(input int budget);
        int cyc;
        int idx;
        n_read = 0; n_mult = 0; n_sum = 0; n_upd = 0; done_cyc = -1;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        while (cyc <= budget && done_cyc < 0) begin
            if (read) n_read++;
            if (load_mult) n_mult++;
            if (load_sum) n_sum++;
            if (load_y && select_y) n_upd++;
            if (done) done_cyc = cyc;
            else if (cyc % 4 == 0) begin
                idx = cyc / 4 - 1;
                if (idx >= act_len) idx = act_len - 1;
                active = act_tab[idx];
            end
            step();
            cyc++;
        end
        busy_after = busy;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; abort = 1'b0; active = 4'b0000;
        step(); step();
        checks++; if ({read, load_y, select_y, load_mult, load_sum} !== 5'b0) begin errors++; $display("FAIL reset_strobes got %b want 00000", {read, load_y, select_y, load_mult, load_sum}); end
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done got %b want 00", {busy, done}); end
        checks++; if ({winner_idx, iter_count, err} !== 12'h000) begin errors++; $display("FAIL reset_outputs got %h want 000", {winner_idx, iter_count, err}); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single_winner();
        act_tab[0] = 4'b0100; act_len = 1;
        run_seq(40);
        checks++; if (done_cyc !== 5) begin errors++; $display("FAIL single_done_cycle got %0d want 5", done_cyc); end
        checks++; if (winner_idx !== 2'd2) begin errors++; $display("FAIL single_winner got %0d want 2", winner_idx); end
        checks++; if (iter_count !== 8'd1) begin errors++; $display("FAIL single_iter got %0d want 1", iter_count); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL single_err got %b want 00", err); end
        checks++; if ({n_read[3:0], n_mult[3:0], n_sum[3:0], n_upd[3:0]} !== 16'h1110) begin errors++; $display("FAIL single_strobes got r%0d m%0d s%0d u%0d want r1 m1 s1 u0", n_read, n_mult, n_sum, n_upd); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b want 0", busy_after); end
    endtask

    task automatic test_converge();
        act_tab[0] = 4'b1111; act_tab[1] = 4'b0110; act_tab[2] = 4'b0010; act_len = 3;
        run_seq(60);
        checks++; if (done_cyc !== 13) begin errors++; $display("FAIL conv_done_cycle got %0d want 13", done_cyc); end
        checks++; if (winner_idx !== 2'd1) begin errors++; $display("FAIL conv_winner got %0d want 1", winner_idx); end
        checks++; if (iter_count !== 8'd3) begin errors++; $display("FAIL conv_iter got %0d want 3", iter_count); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL conv_err got %b want 00", err); end
        checks++; if (n_upd !== 2 || n_read !== 1 || n_sum !== 3) begin errors++; $display("FAIL conv_strobes got u%0d r%0d s%0d want u2 r1 s3", n_upd, n_read, n_sum); end
    endtask

    task automatic test_suppressed();
        act_tab[0] = 4'b1011; act_tab[1] = 4'b0000; act_len = 2;
        run_seq(60);
        checks++; if (done_cyc !== 9) begin errors++; $display("FAIL supp_done_cycle got %0d want 9", done_cyc); end
        checks++; if (err !== 2'b01) begin errors++; $display("FAIL supp_err got %b want 01", err); end
        checks++; if (iter_count !== 8'd2) begin errors++; $display("FAIL supp_iter got %0d want 2", iter_count); end
        checks++; if (winner_idx !== 2'd1) begin errors++; $display("FAIL supp_winner_held got %0d want 1", winner_idx); end
    endtask

    task automatic test_timeout();
        act_tab[0] = 4'b0011; act_len = 1;
        run_seq(120);
        checks++; if (done_cyc !== 65) begin errors++; $display("FAIL tmo_done_cycle got %0d want 65", done_cyc); end
        checks++; if (err !== 2'b10) begin errors++; $display("FAIL tmo_err got %b want 10", err); end
        checks++; if (iter_count !== 8'd16) begin errors++; $display("FAIL tmo_iter got %0d want 16", iter_count); end
        checks++; if (n_sum !== 16) begin errors++; $display("FAIL tmo_checks got %0d want 16", n_sum); end
    endtask

    task automatic test_abort();
        active = 4'b1111;
        start = 1'b1; step();          // cycle 1 LOAD
        start = 1'b0; step();          // cycle 2 MULT
        step();                        // cycle 3 SUM
        start = 1'b1; step();          // cycle 4 CHECK
        start = 1'b0;
        checks++; if (read !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL abort_start_ignored got read=%b busy=%b want 0 1", read, busy); end
        step();                        // cycle 5 UPDATE
        checks++; if ({load_y, select_y} !== 2'b11) begin errors++; $display("FAIL abort_update got %b want 11", {load_y, select_y}); end
        step(); step();                // cycle 7 SUM
        abort = 1'b1; step();          // cycle 8
        abort = 1'b0;
        checks++; if (done !== 1'b1 || err !== 2'b11) begin errors++; $display("FAIL abort_fin got done=%b err=%b want 1 11", done, err); end
        checks++; if (iter_count !== 8'd1) begin errors++; $display("FAIL abort_iter got %0d want 1", iter_count); end
        step();                        // cycle 9
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%b done=%b want 0 0", busy, done); end
        start = 1'b1; abort = 1'b1; step();
        start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0 || read !== 1'b0) begin errors++; $display("FAIL start_abort_idle got busy=%b read=%b want 0 0", busy, read); end
    endtask

    task automatic test_reset_mid_run();
        int seen_done;
        seen_done = 0;
        start = 1'b1; step();
        start = 1'b0; step();          // cycle 2 MULT
        checks++; if (load_mult !== 1'b1) begin errors++; $display("FAIL rst_pre_mult got %b want 1", load_mult); end
        #2 reset = 1'b0;
        #1;
        checks++; if ({load_mult, busy, done} !== 3'b000) begin errors++; $display("FAIL rst_async_ctrl got %b want 000", {load_mult, busy, done}); end
        checks++; if ({winner_idx, iter_count, err} !== 12'h000) begin errors++; $display("FAIL rst_async_outputs got %h want 000", {winner_idx, iter_count, err}); end
        for (int i = 0; i < 4; i++) begin
            step();
            if (done) seen_done++;
        end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL rst_no_done got %0d want 0", seen_done); end
        reset = 1'b1;
        step();
        act_tab[0] = 4'b1000; act_len = 1;
        run_seq(40);
        checks++; if (done_cyc !== 5 || winner_idx !== 2'd3 || iter_count !== 8'd1 || err !== 2'b00) begin errors++; $display("FAIL rst_rerun got cyc=%0d win=%0d it=%0d err=%b want 5 3 1 00", done_cyc, winner_idx, iter_count, err); end
    endtask

    task automatic test_back_to_back();
        active = 4'b0001;
        start = 1'b1;
        for (int c = 1; c <= 5; c++) step();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b want 1", done); end
        step();                        // cycle 6 IDLE, start accepted at this edge
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy=%b want 0", busy); end
        step();                        // cycle 7 LOAD
        start = 1'b0;
        checks++; if (read !== 1'b1 || busy !== 1'b1 || iter_count !== 8'd0) begin errors++; $display("FAIL b2b_reload got read=%b busy=%b it=%0d want 1 1 0", read, busy, iter_count); end
        for (int c = 8; c <= 11; c++) step();
        checks++; if (done !== 1'b1 || winner_idx !== 2'd0 || err !== 2'b00) begin errors++; $display("FAIL b2b_second_done got done=%b win=%0d err=%b want 1 0 00", done, winner_idx, err); end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_single_winner();
        test_converge();
        test_suppressed();
        test_timeout();
        test_abort();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
